// File: rtl/corr_pkg.sv
// Shared definitions for the multi-channel correlation counter: mode encodings,
// count-slot indices and the weight-width helper.
package corr_pkg;

  localparam logic MODE_RECT    = 1'b0;
  localparam logic MODE_LOGDROP = 1'b1;

  typedef enum logic [1:0] {
    CNT_X       = 2'd0,
    CNT_Y       = 2'd1,
    CNT_ISECT   = 2'd2,
    CNT_SYMDIFF = 2'd3
  } cnt_e;

  // Largest weight is 2**time_w (logdrop at t=0), so one extra bit is needed.
  function automatic int unsigned weight_width(input int unsigned time_w);
    return time_w + 1;
  endfunction

endpackage

// File: rtl/corr_weight.sv
// Per-sample weight generator shared by all channels: 1 in rectangular mode,
// 2**(TIME_W - bitlen(t)) in logdrop mode.
module corr_weight
  import corr_pkg::*;
#(
  parameter int unsigned TIME_W = 8
) (
  input  logic [TIME_W-1:0]              t_i,
  input  logic                           mode_i,
  output logic [weight_width(TIME_W)-1:0] w_o
);

  localparam int unsigned WW = weight_width(TIME_W);

  int unsigned bitlen;

  always_comb begin
    bitlen = 0;
    for (int unsigned i = 0; i < TIME_W; i++) begin
      if (t_i[i]) bitlen = i + 1;
    end
    if (mode_i == MODE_LOGDROP) w_o = WW'(1) << (TIME_W - bitlen);
    else                        w_o = WW'(1);
  end

endmodule

// File: rtl/corr_count_multi.sv
// Windowed X/Y/intersection/symmetric-difference counter over N_CH channels
// with a shared timebase and weight generator, result registers and handshake.
module corr_count_multi
  import corr_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TIME_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cg,
  input  logic                     i_restart,
  input  logic                     i_mode,
  input  logic [N_CH-1:0]          i_x,
  input  logic [N_CH-1:0]          i_y,
  output logic [N_CH*DATA_W-1:0]   o_countX,
  output logic [N_CH*DATA_W-1:0]   o_countY,
  output logic [N_CH*DATA_W-1:0]   o_countIsect,
  output logic [N_CH*DATA_W-1:0]   o_countSymdiff,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_overrun,
  output logic [TIME_W-1:0]        o_t
);

  localparam int unsigned WW = weight_width(TIME_W);
  localparam int unsigned AW = DATA_W + 1;
  localparam logic [TIME_W-1:0] T_LAST = '1;

  logic [TIME_W-1:0] t_q, t_d;
  logic              mode_q, mode_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              eff_mode;
  logic              restart;
  logic              complete;
  logic [WW-1:0]     w;

  assign restart  = i_cg & i_restart;
  assign complete = i_cg & ~i_restart & (t_q == T_LAST);
  // The t=0 sample already uses the mode being captured on that edge.
  assign eff_mode = (t_q == '0) ? i_mode : mode_q;

  corr_weight #(.TIME_W(TIME_W)) u_weight (
    .t_i    (t_q),
    .mode_i (eff_mode),
    .w_o    (w)
  );

  always_comb begin
    t_d       = t_q;
    mode_d    = mode_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (restart) begin
      t_d       = '0;
      overrun_d = 1'b0;
    end else if (i_cg) begin
      t_d = t_q + 1'b1;
      if (t_q == '0) mode_d = i_mode;
      if (complete) begin
        valid_d = 1'b1;
        if (valid_q && !i_ready) overrun_d = 1'b1;
      end else if (valid_q && i_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      t_q       <= '0;
      mode_q    <= MODE_RECT;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      t_q       <= t_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_t       = t_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [3:0]             hit;
    logic [3:0][DATA_W-1:0] acc_q, acc_d, res_q, res_d;
    logic [3:0][DATA_W-1:0] sum_sat;
    logic [3:0][AW-1:0]     sum;

    assign hit[CNT_X]       = i_x[c];
    assign hit[CNT_Y]       = i_y[c];
    assign hit[CNT_ISECT]   = i_x[c] & i_y[c];
    assign hit[CNT_SYMDIFF] = i_x[c] ^ i_y[c];

    always_comb begin
      acc_d = acc_q;
      res_d = res_q;
      for (int unsigned k = 0; k < 4; k++) begin
        sum[k]     = {1'b0, acc_q[k]} + (hit[k] ? AW'(w) : '0);
        sum_sat[k] = sum[k][DATA_W] ? '1 : sum[k][DATA_W-1:0];
        if (restart) begin
          acc_d[k] = '0;
        end else if (complete) begin
          res_d[k] = sum_sat[k];
          acc_d[k] = '0;
        end else if (i_cg) begin
          acc_d[k] = sum_sat[k];
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        acc_q <= '0;
        res_q <= '0;
      end else begin
        acc_q <= acc_d;
        res_q <= res_d;
      end
    end

    assign o_countX[c*DATA_W +: DATA_W]       = res_q[CNT_X];
    assign o_countY[c*DATA_W +: DATA_W]       = res_q[CNT_Y];
    assign o_countIsect[c*DATA_W +: DATA_W]   = res_q[CNT_ISECT];
    assign o_countSymdiff[c*DATA_W +: DATA_W] = res_q[CNT_SYMDIFF];
  end

endmodule

// File: tb/tb_corr_count_multi.sv
// Self-checking bench for corr_count_multi: directed scenarios plus random
// traffic checked against a window-sum reference model.
module tb_corr_count_multi;

  localparam int N_CH   = 2;
  localparam int DATA_W = 8;
  localparam int TIME_W = 3;
  localparam int WIN    = 1 << TIME_W;

  logic clk = 1'b0;
  logic rst_n, cg, restart, mode, ready;
  logic [N_CH-1:0] x, y;
  logic [N_CH*DATA_W-1:0] cx, cy, ci, cs;
  logic valid, overrun;
  logic [TIME_W-1:0] t_out;

  logic [3:0] x4, y4, i4, s4;
  logic valid4, overrun4;
  logic [TIME_W-1:0] t4;

  int checks = 0;
  int errors = 0;

  // Reference model: unsaturated window sums; saturation applied at compare.
  int tm, mv, mo, mm;
  int acc[4][N_CH];
  int res[4][N_CH];

  always #5 clk = ~clk;

  corr_count_multi #(.N_CH(N_CH), .DATA_W(DATA_W), .TIME_W(TIME_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_restart(restart), .i_mode(mode),
    .i_x(x), .i_y(y), .o_countX(cx), .o_countY(cy), .o_countIsect(ci),
    .o_countSymdiff(cs), .o_valid(valid), .i_ready(ready), .o_overrun(overrun),
    .o_t(t_out)
  );

  corr_count_multi #(.N_CH(1), .DATA_W(4), .TIME_W(TIME_W)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_restart(restart), .i_mode(mode),
    .i_x(x[0:0]), .i_y(y[0:0]), .o_countX(x4), .o_countY(y4), .o_countIsect(i4),
    .o_countSymdiff(s4), .o_valid(valid4), .i_ready(ready), .o_overrun(overrun4),
    .o_t(t4)
  );

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int weight(int t, int md);
    int k = 0;
    int v = t;
    while (v > 0) begin
      k++;
      v = v >> 1;
    end
    return md ? (WIN >> k) : 1;
  endfunction

  function automatic logic [DATA_W-1:0] cnt(int k, int c);
    case (k)
      0:       return cx[c*DATA_W +: DATA_W];
      1:       return cy[c*DATA_W +: DATA_W];
      2:       return ci[c*DATA_W +: DATA_W];
      default: return cs[c*DATA_W +: DATA_W];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tm = 0; mv = 0; mo = 0; mm = 0;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < N_CH; c++) begin
        acc[k][c] = 0;
        res[k][c] = 0;
      end
  endtask

  task automatic model_step();
    int em, w;
    bit hit;
    if (!cg) return;
    if (restart) begin
      tm = 0;
      mo = 0;
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < N_CH; c++) acc[k][c] = 0;
      return;
    end
    em = (tm == 0) ? int'(mode) : mm;
    if (tm == 0) mm = int'(mode);
    w = weight(tm, em);
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < 4; k++) begin
        case (k)
          0:       hit = x[c];
          1:       hit = y[c];
          2:       hit = x[c] & y[c];
          default: hit = x[c] ^ y[c];
        endcase
        if (hit) acc[k][c] += w;
      end
    if (tm == WIN - 1) begin
      if (mv && !ready) mo = 1;
      mv = 1;
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < N_CH; c++) begin
          res[k][c] = acc[k][c];
          acc[k][c] = 0;
        end
    end else if (mv && ready) begin
      mv = 0;
    end
    tm = (tm + 1) % WIN;
  endtask

  task automatic check_all();
    chk("t", 32'(t_out), tm);
    chk("valid", 32'(valid), mv);
    chk("overrun", 32'(overrun), mo);
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < 4; k++)
        chk($sformatf("cnt%0d_ch%0d", k, c), 32'(cnt(k, c)), min2(res[k][c], 255));
    chk("d4_X", 32'(x4), min2(res[0][0], 15));
    chk("d4_valid", 32'(valid4), mv);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; cg = 1'b0; restart = 1'b0; mode = 1'b0; ready = 1'b0;
    x = '0; y = '0;
    model_reset();
    #12;
    chk("reset_t", 32'(t_out), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_X", 32'(cx), 0);
    check_all();
    rst_n = 1'b1;
    cg = 1'b1;

    // Rectangular window, ch0 x=y=1, ch1 x=1 y=0
    x = 2'b11; y = 2'b01; mode = 1'b0;
    cycles(WIN);
    chk("r032_valid", 32'(valid), 1);
    chk("r032_ch0_X", 32'(cnt(0, 0)), 8);
    chk("r032_ch0_Y", 32'(cnt(1, 0)), 8);
    chk("r032_ch0_I", 32'(cnt(2, 0)), 8);
    chk("r032_ch0_S", 32'(cnt(3, 0)), 0);
    chk("r032_ch1_X", 32'(cnt(0, 1)), 8);
    chk("r032_ch1_Y", 32'(cnt(1, 1)), 0);
    chk("r032_ch1_I", 32'(cnt(2, 1)), 0);
    chk("r032_ch1_S", 32'(cnt(3, 1)), 8);

    // Logdrop: full window, ready held low so this also overruns
    x = 2'b01; y = 2'b00; mode = 1'b1;
    cycles(WIN);
    chk("r033_full_X", 32'(cnt(0, 0)), 20);
    chk("r034_sat_X", 32'(x4), 15);
    chk("r035_overrun", 32'(overrun), 1);
    chk("r035_valid", 32'(valid), 1);
    x = 2'b00; cycles(4);
    x = 2'b01; cycles(4);
    chk("r033_tail_X", 32'(cnt(0, 0)), 4);
    x = 2'b01; cycle();
    x = 2'b00; cycles(WIN - 1);
    chk("r033_t0_X", 32'(cnt(0, 0)), 8);

    // Restart at t=5 clears overrun, leaves valid and results
    mode = 1'b0; x = 2'b01;
    cycles(5);
    chk("r036_t5", 32'(t_out), 5);
    restart = 1'b1; cycle(); restart = 1'b0;
    chk("r035_ovr_clr", 32'(overrun), 0);
    chk("r035_valid_kept", 32'(valid), 1);
    chk("r036_t_zero", 32'(t_out), 0);
    chk("r036_res_kept", 32'(cnt(0, 0)), 8);
    cycles(WIN);
    chk("r036_restart_X", 32'(cnt(0, 0)), 8);

    // Clock gate low for three cycles mid-window
    cycles(3);
    cg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("r036_cg_t", 32'(t_out), 3);
    end
    cg = 1'b1;
    cycles(WIN - 3);
    chk("r036_cg_X", 32'(cnt(0, 0)), 8);

    // Consume the result
    ready = 1'b1; cycle(); ready = 1'b0;
    chk("r021_valid_clr", 32'(valid), 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      x       = N_CH'($urandom);
      y       = N_CH'($urandom);
      mode    = 1'($urandom);
      ready   = ($urandom_range(0, 2) == 0);
      restart = ($urandom_range(0, 24) == 0);
      cg      = ($urandom_range(0, 7) != 0);
      cycle();
    end
    restart = 1'b0; cg = 1'b1; ready = 1'b0;

    // Asynchronous reset mid-window
    x = 2'b11; mode = 1'b0;
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("r037_t", 32'(t_out), 0);
    chk("r037_valid", 32'(valid), 0);
    chk("r037_X", 32'(cx), 0);
    chk("r037_S", 32'(cs), 0);
    chk("r037_d4", 32'(x4), 0);
    check_all();
    #1 rst_n = 1'b1;
    x = 2'b01; y = 2'b00;
    cycles(WIN);
    chk("r037_after_X", 32'(cnt(0, 0)), 8);
    chk("r037_after_valid", 32'(valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/corr_count_multi.md
CORR_COUNT_MULTI -- requirements
Module: corr_count_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent x/y channel pairs (>=1).
REQ-002 Parameter DATA_W, default 8, width of each count (SHALL be >= TIME_W+1).
REQ-003 Parameter TIME_W, default 8, window length 2**TIME_W samples.
REQ-004 i_clk  in  1  sole clock; all state on rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_cg  in  1  clock-gate enable; 0 holds all state.
REQ-007 i_restart  in  1  synchronous abort of current window.
REQ-008 i_mode  in  1  window weighting: 0=rectangular, 1=logdrop.
REQ-009 i_x, i_y  in  N_CH each  per-channel sample bits.
REQ-010 o_countX, o_countY, o_countIsect, o_countSymdiff  out  N_CH*DATA_W each  result counts, channel c at bits [c*DATA_W +: DATA_W].
REQ-011 o_valid  out  1  result registers hold an unconsumed window result.
REQ-012 i_ready  in  1  consumer accepts result.
REQ-013 o_overrun  out  1  sticky: an unconsumed result was overwritten.
REQ-014 o_t  out  TIME_W  sample index within current window.

Function
REQ-015 With i_cg=1, t SHALL increment each cycle, wrapping 2**TIME_W-1 -> 0; with i_cg=0 no register changes.
REQ-016 Effective mode SHALL be captured from i_mode when t=0 is sampled and held for the whole window.
REQ-017 Weight w(t) SHALL be 1 in rectangular mode; in logdrop mode 2**(TIME_W-k), k = bit-length of t (k=0 for t=0).
REQ-018 Per channel, each cycle, accumulators SHALL add w(t) to X if x, Y if y, Isect if x&y, Symdiff if x^y.
REQ-019 Accumulators SHALL saturate at 2**DATA_W-1, never wrap.
REQ-020 Sample at t=2**TIME_W-1 SHALL be included; next cycle result registers hold the final sums, o_valid=1, accumulators restart from zero with the t=0 sample.
REQ-021 o_valid SHALL clear on the cycle after o_valid&i_ready unless a new result loads in that same edge.
REQ-022 Completion while o_valid=1 and i_ready=0: result SHALL be overwritten, o_valid stays 1, o_overrun set.
REQ-023 Completion while o_valid&i_ready: new result loads, o_valid stays 1, o_overrun unchanged.
REQ-024 Result registers SHALL be stable while o_valid=1 and no completion occurs.
REQ-025 i_restart=1 (with i_cg=1) SHALL zero t and all accumulators, discard the partial window, clear o_overrun, and not alter result registers or o_valid; the sample of that cycle is discarded.
REQ-026 i_restart coinciding with completion: restart wins, no result loads.

Reset
REQ-027 On i_rst_n=0: t=0, accumulators=0, result registers=0, o_valid=0, o_overrun=0, captured mode=0, independent of i_clk and i_cg.
REQ-028 Reset deassertion SHALL be synchronised by the integrating design; first sample after release is t=0.

Structure
REQ-029 Shared package corr_pkg SHALL hold mode constants (MODE_RECT, MODE_LOGDROP) and the weight-width function.
REQ-030 Weight generation SHALL be a sub-module corr_weight (t, mode -> w), instantiated once and shared by all channels.
REQ-031 Per-channel accumulate/saturate logic SHALL be a generate loop over N_CH; no per-channel timebase.

Verification (N_CH=2, DATA_W=8, TIME_W=3 unless stated)
REQ-032 Rect, ch0 x=y=1, ch1 x=1 y=0 for 8 cycles -> ch0 X=8 Y=8 Isect=8 Symdiff=0; ch1 X=8 Y=0 Isect=0 Symdiff=8; o_valid=1.
REQ-033 Logdrop, ch0 x=1 all window -> X=20; x=1 only t=4..7 -> X=4; x=1 only t=0 -> X=8.
REQ-034 DATA_W=4, logdrop, x=1 all window -> X=15 (saturated), not 4.
REQ-035 i_ready=0 across two completions -> second result visible, o_overrun=1; i_restart -> o_overrun=0, o_valid still 1.
REQ-036 i_restart at t=5 mid-window, then full window with x=1 (rect) -> X=8; i_cg=0 for 3 cycles mid-window -> o_t and counts frozen, final X unchanged.
REQ-037 i_rst_n low mid-window asynchronously -> all outputs 0 immediately; next window counts from t=0.
